// File: rtl/apb_multi_master_pkg.sv
// apb_pkg: types shared by the APB requester.
//   apb_state_e : requester FSM states
//   apb_cmd_t   : command captured at the cmd handshake
// The struct is sized for the widest supported build (32-bit address and data);
// narrower instances zero-extend into it and slice back out.
package apb_pkg;

  localparam int ADDR_W_MAX = 32;
  localparam int DATA_W_MAX = 32;
  localparam int STRB_W     = DATA_W_MAX / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic                  write;
    logic [DATA_W_MAX-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_multi_master_if.sv
// apb_multi_master_if: command/response stream plus APB4 fabric signals.
//   master modport : requester side (accepts commands, drives APB, returns responses)
//   slave  modport : front end and slave fabric side
interface apb_multi_master_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
) ();

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [ADDR_W-1:0]            cmd_addr;
  logic                         cmd_write;
  logic [DATA_W-1:0]            cmd_wdata;
  logic [DATA_W/8-1:0]          cmd_strb;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;

  logic [ADDR_W-1:0]            PADDR;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [DATA_W-1:0]            PWDATA;
  logic [DATA_W/8-1:0]          PSTRB;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_multi_master_timeout_ctr.sv
// apb_timeout_ctr: counts un-ready ACCESS cycles.
//   PCLK, PRESET : clock, synchronous active-high reset
//   clear        : force count to 0 (held during SETUP)
//   enable       : count one more wait cycle
//   expired      : count has reached TIMEOUT-1
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Saturates at the terminal value; the FSM leaves ACCESS there anyway.
  always_ff @(posedge PCLK) begin
    if (PRESET || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_multi_master.sv
// apb_multi_master: APB4 requester fed by a valid/ready command stream.
//   PCLK, PRESET : clock, synchronous active-high reset
//   bus (master) : cmd_* in, rsp_* out, APB4 outputs, per-slave PRDATA/PREADY/PSLVERR in
// Slave index is the address above the per-slave window; indices past
// NUM_SLAVES return a decode error without touching the fabric.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL[idx] high, PENABLE low, one cycle
//   ACCESS | PSEL[idx] and PENABLE high until PREADY[idx] or timeout
//   RESP   | rsp_valid high, response held until rsp_ready
module apb_multi_master
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_ADDR_W = 12,
  parameter int TIMEOUT    = 16
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_multi_master_if.master bus
);

  localparam int STRB_LW = DATA_W / 8;
  localparam int IDX_W   = ADDR_W - SLV_ADDR_W;
  localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  apb_state_e          state_q, state_d;
  apb_cmd_t            cmd_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [NUM_SLAVES-1:0] psel;
  logic                cmd_ready, rsp_valid, penable;
  logic                expired;

  logic [IDX_W-1:0]    cmd_idx;
  logic                decode_ok;
  logic                slv_ready, slv_err;
  logic [DATA_W-1:0]   slv_rdata;

  assign cmd_idx   = bus.cmd_addr[ADDR_W-1:SLV_ADDR_W];
  assign decode_ok = (cmd_idx < IDX_W'(NUM_SLAVES));

  // Only the addressed slave's handshake lines are looked at.
  assign slv_ready = bus.PREADY[sel_q];
  assign slv_err   = bus.PSLVERR[sel_q];
  assign slv_rdata = bus.PRDATA[sel_q*DATA_W +: DATA_W];

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !slv_ready),
    .expired (expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    penable   = 1'b0;
    psel      = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_d = decode_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        psel[sel_q] = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        psel[sel_q] = 1'b1;
        penable     = 1'b1;
        // PREADY wins over a timeout landing in the same cycle.
        if (slv_ready || expired) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmd_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q.addr  <= ADDR_W_MAX'(bus.cmd_addr);
            cmd_q.write <= bus.cmd_write;
            cmd_q.wdata <= DATA_W_MAX'(bus.cmd_wdata);
            cmd_q.strb  <= bus.cmd_write ? STRB_W'(bus.cmd_strb) : '0;
            sel_q       <= SEL_W'(cmd_idx);
            rdata_q     <= '0;
            err_q       <= !decode_ok;
          end
        end
        ACCESS: begin
          if (slv_ready) begin
            rdata_q <= (!cmd_q.write && !slv_err) ? slv_rdata : '0;
            err_q   <= slv_err;
          end else if (expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PADDR     = cmd_q.addr[ADDR_W-1:0];
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = cmd_q.write;
  assign bus.PWDATA    = cmd_q.wdata[DATA_W-1:0];
  assign bus.PSTRB     = cmd_q.strb[STRB_LW-1:0];

endmodule

// File: tb/tb_apb_multi_master.sv
module tb_apb_multi_master;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 4;
  localparam int SLV_ADDR_W = 12;
  localparam int TIMEOUT    = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_multi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES)) bus ();

  apb_multi_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
    .SLV_ADDR_W(SLV_ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave fabric model: the selected slave becomes ready after wait_cfg
  // un-ready ACCESS cycles; unselected slaves show PREADY=1 and their own
  // PSLVERR/PRDATA so that any wrong-slice sampling is visible.
  int          wait_cfg = 0;
  logic [3:0]  err_cfg  = '0;
  logic [31:0] data_cfg [4];
  int          acc_cnt  = 0;

  always @(posedge PCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus.PRDATA[i*DATA_W +: DATA_W] = data_cfg[i];
      bus.PREADY[i]  = bus.PSEL[i] ? (bus.PENABLE && (acc_cnt >= wait_cfg)) : 1'b1;
      bus.PSLVERR[i] = err_cfg[i];
    end
  end

  // Observations from one transaction (cycle 0 = handshake cycle)
  int          o_first_sel, o_sel_n, o_en, o_rsp_cyc;
  logic [3:0]  o_psel;
  logic [31:0] o_rdata;
  logic        o_err, o_fields_ok, o_hold_ok;

  // Expected values from the reference model
  int          e_sel_n, e_en, e_rsp_cyc;
  logic [3:0]  e_psel;
  logic [31:0] e_rdata;
  logic        e_err;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level model: outcome of one command given the slave setup.
  task automatic model(input logic [31:0] addr, input logic wr, input int wt);
    int  idx;
    bit  tmo;
    idx = int'(addr >> SLV_ADDR_W);
    if (addr >= 32'(NUM_SLAVES) << SLV_ADDR_W) begin
      e_psel = '0; e_sel_n = 0; e_en = 0; e_rsp_cyc = 1; e_err = 1'b1; e_rdata = '0;
    end else begin
      tmo       = (wt >= TIMEOUT);
      e_psel    = 4'(1 << idx);
      e_en      = tmo ? TIMEOUT : wt + 1;
      e_sel_n   = e_en + 1;
      e_rsp_cyc = e_en + 2;
      e_err     = tmo || err_cfg[idx];
      e_rdata   = (e_err || wr) ? 32'h0 : data_cfg[idx];
    end
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input int hold);
    o_first_sel = -1; o_sel_n = 0; o_en = 0; o_rsp_cyc = -1; o_psel = '0;
    o_rdata = '0; o_err = 1'b0; o_fields_ok = 1'b1; o_hold_ok = 1'b1;
    for (int k = 0; k < 8 && !bus.cmd_ready; k++) tick();
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 1; c < 64; c++) begin
      if (bus.PSEL != '0) begin
        if (o_first_sel < 0) o_first_sel = c;
        o_sel_n++;
        o_psel = o_psel | bus.PSEL;
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PSTRB !== (wr ? st : 4'h0) ||
            (wr && bus.PWDATA !== wd))
          o_fields_ok = 1'b0;
      end
      if (bus.PENABLE) o_en++;
      if (bus.rsp_valid) begin
        o_rsp_cyc = c;
        o_rdata   = bus.rsp_rdata;
        o_err     = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
          tick();
          if (!bus.rsp_valid || bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err || bus.cmd_ready)
            o_hold_ok = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) data_cfg[i] = $urandom;
    repeat (3) tick();
    PRESET = 1'b0;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err});
    end
    n_checks++;
    if ({bus.PADDR, bus.PWDATA, bus.PSTRB, bus.rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.rsp_rdata});
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    wait_cfg = 0; err_cfg = 4'b0101;
    run_txn(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    n_checks++;
    if (o_first_sel !== 1 || o_sel_n !== 2 || o_psel !== 4'b0010) begin
      n_fail++;
      $display("FAIL wr_psel: got first=%0d n=%0d psel=%b required 1 2 0010", o_first_sel, o_sel_n, o_psel);
    end
    n_checks++;
    if (o_rsp_cyc !== 3 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rsp: got cyc=%0d err=%b rdata=%h required 3 0 0", o_rsp_cyc, o_err, o_rdata);
    end
    n_checks++;
    if (!o_fields_ok) begin
      n_fail++;
      $display("FAIL wr_fields: got unstable/wrong APB fields required PADDR=1004 PSTRB=f PWDATA=deadbeef");
    end
  endtask

  task automatic test_read_wait();
    wait_cfg = 3; err_cfg = 4'b1011; data_cfg[2] = 32'h1234_5678;
    run_txn(32'h0000_2000, 1'b0, $urandom, 4'($urandom), 0);
    n_checks++;
    if (o_en !== 4 || o_psel !== 4'b0100) begin
      n_fail++;
      $display("FAIL rd_wait_enable: got en=%0d psel=%b required 4 0100", o_en, o_psel);
    end
    n_checks++;
    if (o_rdata !== 32'h1234_5678 || o_err !== 1'b0 || o_rsp_cyc !== 6) begin
      n_fail++;
      $display("FAIL rd_wait_rsp: got rdata=%h err=%b cyc=%0d required 12345678 0 6", o_rdata, o_err, o_rsp_cyc);
    end
    n_checks++;
    if (!o_fields_ok) begin
      n_fail++;
      $display("FAIL rd_fields: got wrong APB fields required PADDR=2000 PWRITE=0 PSTRB=0");
    end
  endtask

  task automatic test_decode_error();
    wait_cfg = 0; err_cfg = '0;
    run_txn(32'h0000_5000, 1'b0, 32'h0, 4'h0, 0);
    n_checks++;
    if (o_psel !== 4'b0000 || o_en !== 0) begin
      n_fail++;
      $display("FAIL dec_psel: got psel=%b en=%0d required 0000 0", o_psel, o_en);
    end
    n_checks++;
    if (o_rsp_cyc !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL dec_rsp: got cyc=%0d err=%b rdata=%h required 1 1 0", o_rsp_cyc, o_err, o_rdata);
    end
  endtask

  task automatic test_timeout();
    wait_cfg = 1000; err_cfg = '0; data_cfg[0] = 32'hA5A5_5A5A;
    run_txn(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0);
    n_checks++;
    if (o_en !== TIMEOUT || o_sel_n !== TIMEOUT + 1 || o_psel !== 4'b0001) begin
      n_fail++;
      $display("FAIL tmo_len: got en=%0d sel=%0d psel=%b required %0d %0d 0001", o_en, o_sel_n, o_psel, TIMEOUT, TIMEOUT + 1);
    end
    n_checks++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_rsp_cyc !== TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL tmo_rsp: got err=%b rdata=%h cyc=%0d required 1 0 %0d", o_err, o_rdata, o_rsp_cyc, TIMEOUT + 2);
    end
  endtask

  task automatic test_slverr_backpressure();
    wait_cfg = 0; err_cfg = 4'b1000; data_cfg[3] = 32'hFFFF_0000;
    run_txn(32'h0000_3008, 1'b1, 32'h0BAD_F00D, 4'h3, 5);
    n_checks++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_rsp_cyc !== 3 || o_psel !== 4'b1000) begin
      n_fail++;
      $display("FAIL slverr_rsp: got err=%b rdata=%h cyc=%0d psel=%b required 1 0 3 1000", o_err, o_rdata, o_rsp_cyc, o_psel);
    end
    n_checks++;
    if (!o_hold_ok) begin
      n_fail++;
      $display("FAIL slverr_hold: got response change or cmd_ready during stall required stable");
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_release: got cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    logic seen_rsp;
    wait_cfg = 1000; err_cfg = '0;
    bus.cmd_addr = 32'h0000_0100; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got PENABLE=%b PSEL=%b required 1 0001", bus.PENABLE, bus.PSEL);
    end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    n_checks++;
    if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_post: got PSEL=%b PENABLE=%b rsp_valid=%b cmd_ready=%b required 0000 0 0 1",
               bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready);
    end
    seen_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    n_checks++;
    if (seen_rsp) begin
      n_fail++;
      $display("FAIL rst_mid_norsp: got rsp_valid after reset required none");
    end
    wait_cfg = 0; data_cfg[1] = 32'hCAFE_0001;
    run_txn(32'h0000_1010, 1'b0, 32'h0, 4'h0, 0);
    n_checks++;
    if (o_rsp_cyc !== 3 || o_err !== 1'b0 || o_rdata !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL rst_mid_after: got cyc=%0d err=%b rdata=%h required 3 0 cafe0001", o_rsp_cyc, o_err, o_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd;
    logic        wr;
    logic [3:0]  st;
    int          wt, hold, sel;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 5);
      addr = (32'(sel) << SLV_ADDR_W) | 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      wr   = 1'($urandom);
      wd   = $urandom;
      st   = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       wt = TIMEOUT - 1;
        1:       wt = TIMEOUT + $urandom_range(0, 3);
        default: wt = $urandom_range(0, 3);
      endcase
      hold = $urandom_range(0, 2);
      wait_cfg = wt;
      err_cfg  = 4'($urandom);
      for (int i = 0; i < 4; i++) data_cfg[i] = $urandom;
      model(addr, wr, wt);
      run_txn(addr, wr, wd, st, hold);
      n_checks++;
      if (o_rsp_cyc !== e_rsp_cyc || o_err !== e_err || o_rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got cyc=%0d err=%b rdata=%h required %0d %b %h (addr=%h wr=%b wait=%0d)",
                 n, o_rsp_cyc, o_err, o_rdata, e_rsp_cyc, e_err, e_rdata, addr, wr, wt);
      end
      n_checks++;
      if (o_psel !== e_psel || o_en !== e_en || o_sel_n !== e_sel_n) begin
        n_fail++;
        $display("FAIL rand_apb[%0d]: got psel=%b en=%0d sel=%0d required %b %0d %0d",
                 n, o_psel, o_en, o_sel_n, e_psel, e_en, e_sel_n);
      end
      n_checks++;
      if (!o_fields_ok || !o_hold_ok) begin
        n_fail++;
        $display("FAIL rand_stable[%0d]: got fields_ok=%b hold_ok=%b required 1 1", n, o_fields_ok, o_hold_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_error();
    test_timeout();
    test_slverr_backpressure();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
